// File: rtl/fp32_pkg.sv
// fp32_pkg: shared types and constants for the fp32 subtractor
package fp32_pkg;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_e;
  localparam int BIAS = 127;
  localparam int EXP_MAX = 255;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam int EXT_W = 27;
endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: leading-zero count of a 28-bit value plus all-zero indication
module fp_lzc (
  input  logic [27:0] value,
  output logic [4:0]  cnt,
  output logic        all_zero
);
  always_comb begin
    cnt = 5'd0;
    for (int i = 0; i < 28; i++) cnt = value[i] ? 5'(27 - i) : cnt;
  end
  assign all_zero = ~|value;
endmodule

// File: rtl/fp32_subtractor.sv
// fp32_subtractor: multi-cycle IEEE-754 binary32 a - b with round-to-nearest-even behind valid/ready
module fp32_subtractor
  import fp32_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   flag_inv,
  output logic                   flag_ovf
);
  state_e state, state_d;
  fp32_t ra, rb;
  logic sx, sy, spec, spec_inv, sign_n, uf_n;
  logic [31:0] spec_res;
  logic [7:0] ex, d;
  logic [EXT_W-1:0] mx, my, mn, ext_y, sh_y;
  logic [EXT_W:0] sum;
  logic signed [9:0] en, e_norm, e_r;
  logic a_nan, b_nan, a_inf, b_inf, inv, swap, sticky, all_zero, inc, zero, ovf;
  logic [23:0] sig_a, sig_b, sig_y, m_r;
  logic [4:0] lz;
  always_ff @(posedge clk) state <= rst ? IDLE : state_d;
  always_comb begin
    state_d = state == IDLE ? (in_valid ? ALIGN : IDLE) :
              state == DONE ? (out_ready ? IDLE : DONE) : state_e'(state + 3'd1);
  end
  assign in_ready = (state == IDLE) & ~rst;
  assign out_valid = state == DONE;
  assign a_nan = &ra.exp & |ra.man;
  assign b_nan = &rb.exp & |rb.man;
  assign a_inf = &ra.exp & ~|ra.man;
  assign b_inf = &rb.exp & ~|rb.man;
  assign inv = a_nan | b_nan | (a_inf & b_inf & (ra.sign ^ rb.sign));
  assign sig_a = {|ra.exp, ra.man & {23{|ra.exp}}};
  assign sig_b = {|rb.exp, rb.man & {23{|rb.exp}}};
  assign swap = {rb.exp, sig_b[22:0]} > {ra.exp, sig_a[22:0]};
  assign d = swap ? rb.exp - ra.exp : ra.exp - rb.exp;
  assign sig_y = swap ? sig_a : sig_b;
  assign ext_y = {sig_y, 3'b000};
  assign sh_y = d >= 8'(EXT_W) ? '0 : ext_y >> d;
  assign sticky = d >= 8'(EXT_W) ? |sig_y : (sh_y << d) != ext_y;
  fp_lzc lzc (.value(sum), .cnt(lz), .all_zero(all_zero));
  // sum[27] is the carry slot, so a normalised value has lz == 1 and keeps ex
  assign e_norm = sum[EXT_W] ? $signed({2'b00, ex}) + 10'sd1 :
                  $signed({2'b00, ex}) + 10'sd1 - $signed({5'b00000, lz});
  assign inc = mn[2] & (mn[1] | mn[0] | mn[3]);
  assign m_r = {1'b0, mn[25:3]} + {23'd0, inc};
  assign e_r = en + $signed({9'd0, m_r[23]});
  // mn[26] is the hidden bit; it is clear only when the difference was exactly zero
  assign zero = ~mn[26] | uf_n;
  assign ovf = e_r >= 10'(EXP_MAX);
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      ra <= a;
      rb <= {~b[31], b[30:0]};
    end
    if (state == ALIGN) begin
      sx <= swap ? rb.sign : ra.sign;
      sy <= swap ? ra.sign : rb.sign;
      ex <= swap ? rb.exp : ra.exp;
      mx <= {swap ? sig_b : sig_a, 3'b000};
      my <= {sh_y[EXT_W-1:1], sh_y[0] | sticky};
      spec <= a_nan | b_nan | a_inf | b_inf;
      spec_inv <= inv;
      spec_res <= inv ? QNAN : a_inf ? ra : {rb.sign, POS_INF[30:0]};
    end
    if (state == ADD) sum <= sx == sy ? {1'b0, mx} + {1'b0, my} : {1'b0, mx} - {1'b0, my};
    if (state == NORM) begin
      mn <= sum[EXT_W] ? {sum[EXT_W:2], sum[1] | sum[0]} : sum[EXT_W-1:0] << (lz - 5'd1);
      en <= e_norm;
      uf_n <= e_norm <= 10'sd0;
      sign_n <= all_zero ? sx & sy : sx;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      flag_inv <= 1'b0;
      flag_ovf <= 1'b0;
    end else if (state == ROUND) begin
      result <= spec ? spec_res : zero ? {sign_n, 31'd0} :
                ovf ? {sign_n, POS_INF[30:0]} : {sign_n, e_r[7:0], m_r[22:0]};
      flag_inv <= spec_inv;
      flag_ovf <= ~spec & ~zero & ovf;
    end
  end
endmodule

// File: tb/tb_fp32_subtractor.sv
// tb_fp32_subtractor: randomized and directed checks of fp32_subtractor against an exact-arithmetic model
module tb_fp32_subtractor;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, flag_inv, flag_ovf;
  logic [31:0] a = 0, b = 0, result, held;
  int errors = 0, checks = 0, bp_mode = 2;
  logic [33:0] exp_q[$];
  always #5 clk = ~clk;
  fp32_subtractor dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_inv(flag_inv), .flag_ovf(flag_ovf)
  );
  // exact difference on a 2^-149 grid, then RNE to 24 bits; {inv, ovf, result}
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y);
    logic sa, sb, sd;
    int ea, eb, p, be;
    logic [279:0] va, vb, df, m, rem, half;
    sa = x[31];
    sb = ~y[31];
    ea = int'(x[30:23]);
    eb = int'(y[30:23]);
    if ((ea == 255 && x[22:0] != 0) || (eb == 255 && y[22:0] != 0)) return {2'b10, 32'h7FC00000};
    if (ea == 255 && eb == 255) return sa != sb ? {2'b10, 32'h7FC00000} : {2'b00, x};
    if (ea == 255) return {2'b00, x};
    if (eb == 255) return {2'b00, sb, 31'h7F800000};
    va = ea == 0 ? '0 : ({256'd0, 1'b1, x[22:0]} << (ea - 1));
    vb = eb == 0 ? '0 : ({256'd0, 1'b1, y[22:0]} << (eb - 1));
    if (sa == sb) begin df = va + vb; sd = sa; end
    else if (va >= vb) begin df = va - vb; sd = sa; end
    else begin df = vb - va; sd = sb; end
    if (df == 0) return {2'b00, sa & sb, 31'd0};
    p = -1;
    for (int i = 0; i < 280; i++) if (df[i]) p = i;
    if (p < 23) return {2'b00, sd, 31'd0};
    m = df >> (p - 23);
    rem = df - (m << (p - 23));
    if (p >= 24) begin
      half = 280'd1 << (p - 24);
      if (rem > half || (rem == half && m[0])) m = m + 1;
    end
    be = p - 22;
    if (m[24]) begin m = m >> 1; be++; end
    if (be >= 255) return {2'b01, sd, 31'h7F800000};
    return {2'b00, sd, be[7:0], m[22:0]};
  endfunction
  task automatic chk(input string name, input logic [33:0] got, input logic [33:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask
  always @(negedge clk) if (!rst && out_valid) begin
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL spurious_out_valid: got result %h with no op in flight", result);
    end else begin
      chk("result", {flag_inv, flag_ovf, result}, exp_q[0]);
      if (out_ready) void'(exp_q.pop_front());
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = bp_mode == 1 ? 1'b0 : bp_mode == 2 ? 1'b1 : 1'($urandom_range(0, 3) != 0);
  end
  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    if (exp_q.size() != 0) begin
      chk("handoff_timeout", 34'(exp_q.size()), 34'(0));
      exp_q.delete();
    end
  endtask
  task automatic op(input logic [31:0] x, input logic [31:0] y, input bit wd);
    int n = 0;
    @(negedge clk);
    a = x;
    b = y;
    in_valid = 1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) chk("accept_timeout", 34'(in_ready), 34'(1));
    exp_q.push_back(model(x, y));
    @(posedge clk);
    #1;
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency", 34'(n), 34'(4));
    if (wd) wait_done();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    chk("model 3-1", model(32'h40400000, 32'h3F800000), {2'b00, 32'h40000000});
    chk("model 1-1", model(32'h3F800000, 32'h3F800000), {2'b00, 32'h00000000});
    chk("model -0-0", model(32'h80000000, 32'h00000000), {2'b00, 32'h80000000});
    chk("model cancel", model(32'h3F800000, 32'h3F7FFFFF), {2'b00, 32'h33800000});
    chk("model tie", model(32'h3F800000, 32'h33000000), {2'b00, 32'h3F800000});
    chk("model inf-inf", model(32'h7F800000, 32'h7F800000), {2'b10, 32'h7FC00000});
    chk("model ovf", model(32'h7F7FFFFF, 32'hFF7FFFFF), {2'b01, 32'h7F800000});
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 34'(in_ready), 34'(0));
    chk("reset outputs", {out_valid, flag_inv, flag_ovf, result}, 35'(0));
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("idle in_ready", 34'(in_ready), 34'(1));
    op(32'h40400000, 32'h3F800000, 1);
    op(32'h3F800000, 32'h3F800000, 1);
    op(32'h80000000, 32'h00000000, 1);
    op(32'h3F800000, 32'h3F7FFFFF, 1);
    op(32'h3F800000, 32'h33000000, 1);
    op(32'h7F800000, 32'h7F800000, 1);
    op(32'h7F7FFFFF, 32'hFF7FFFFF, 1);
    op(32'h3F800000, 32'hFF800000, 1);
    op(32'h7FC00001, 32'h3F800000, 1);
    bp_mode = 1;
    @(posedge clk);
    #1;
    op(32'h40400000, 32'h3F800000, 0);
    held = result;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = 32'h12345678;
      b = 32'h9ABCDEF0;
      in_valid = 1;
      chk("stall in_ready", 34'(in_ready), 34'(0));
      chk("stall stable", {flag_inv, flag_ovf, result}, {2'b00, held});
    end
    in_valid = 0;
    bp_mode = 2;
    wait_done();
    repeat (8) @(posedge clk);
    @(negedge clk);
    a = 32'h40400000;
    b = 32'h3F800000;
    in_valid = 1;
    chk("pre-abort in_ready", 34'(in_ready), 34'(1));
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("abort in_ready", 34'(in_ready), 34'(1));
    chk("abort out_valid", 34'(out_valid), 34'(0));
    repeat (8) @(posedge clk);
    op(32'h40400000, 32'h3F800000, 1);
    bp_mode = 0;
    for (int i = 0; i < 150; i++) begin
      int ea, eb;
      logic [31:0] x, y;
      ea = int'($urandom_range(1, 254));
      eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : ea + int'($urandom_range(0, 6)) - 3;
      if ($urandom_range(0, 15) == 0) ea = $urandom_range(0, 1) == 0 ? 0 : 255;
      if (eb < 0) eb = 0;
      if (eb > 255) eb = 255;
      x = {1'($urandom), 8'(ea), 23'($urandom)};
      y = {1'($urandom), 8'(eb), 23'($urandom)};
      if ($urandom_range(0, 7) == 0) y[22:0] = x[22:0];
      if ($urandom_range(0, 7) == 0) x[22:0] = 23'd0;
      op(x, y, 1);
    end
    bp_mode = 2;
    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
